// File: rtl/status_stack_if.sv
// Bus bundle for the CP0 status stack: push/pop/direct-write commands
// in, stacked status word, popped field, depth and sticky flags out.
interface status_stack_if #(
    parameter int WIDTH   = 32,
    parameter int FIELD_W = 4
);
    localparam int DEPTH = WIDTH / FIELD_W;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic               push;
    logic               pop;
    logic [FIELD_W-1:0] new_field;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_data;
    logic               clr_flags;
    logic [WIDTH-1:0]   status_q;
    logic [FIELD_W-1:0] popped_field;
    logic [LVL_W-1:0]   level;
    logic               ovf;
    logic               udf;

    modport master (
        output push, pop, new_field, wr_en, wr_data, clr_flags,
        input  status_q, popped_field, level, ovf, udf
    );

    modport slave (
        input  push, pop, new_field, wr_en, wr_data, clr_flags,
        output status_q, popped_field, level, ovf, udf
    );
endinterface

// File: rtl/status_stack_reg.sv
// Registered status word held as a stack of FIELD_W-bit fields.
// Ports: clk, rst_n (sync, active low), bus (status_stack_if.slave):
//   push/pop/new_field, wr_en/wr_data, clr_flags in;
//   status_q, popped_field, level, ovf, udf out (all registered).
// Optional macro STATUS_STACK_ROTATE_EN: pop-only rotates the popped
// field back into the top slot instead of zero-filling it.
module status_stack_reg #(
    parameter int               WIDTH     = 32,
    parameter int               FIELD_W   = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h0000_0000)
) (
    input  logic          clk,
    input  logic          rst_n,
    status_stack_if.slave bus
);
    localparam int DEPTH = WIDTH / FIELD_W;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    logic [WIDTH-1:0]   status_q, status_d;
    logic [FIELD_W-1:0] popped_q, popped_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               ovf_set, udf_set;

    always_comb begin
        status_d = status_q;
        popped_d = popped_q;
        level_d  = level_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        if (bus.wr_en) begin
            status_d = bus.wr_data;
            level_d  = '0;
        end else if (bus.push && bus.pop) begin
            // Return then immediate re-entry: only the bottom slot changes.
            status_d = {status_q[WIDTH-1:FIELD_W], bus.new_field};
            popped_d = status_q[FIELD_W-1:0];
        end else if (bus.push) begin
            status_d = {status_q[WIDTH-FIELD_W-1:0], bus.new_field};
            if (level_q < LVL_MAX) level_d = level_q + 1'b1;
            else                   ovf_set = 1'b1;
        end else if (bus.pop) begin
`ifdef STATUS_STACK_ROTATE_EN
            status_d = {status_q[FIELD_W-1:0], status_q[WIDTH-1:FIELD_W]};
`else
            status_d = {{FIELD_W{1'b0}}, status_q[WIDTH-1:FIELD_W]};
`endif
            popped_d = status_q[FIELD_W-1:0];
            if (level_q != '0) level_d = level_q - 1'b1;
            else               udf_set = 1'b1;
        end
        // A flag being set this cycle beats a clear request.
        ovf_d = (ovf_q & ~bus.clr_flags) | ovf_set;
        udf_d = (udf_q & ~bus.clr_flags) | udf_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= RESET_VAL;
            popped_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            popped_q <= popped_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus.status_q     = status_q;
    assign bus.popped_field = popped_q;
    assign bus.level        = level_q;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
endmodule

// File: tb/tb_status_stack_reg.sv
// Directed self-checking bench for status_stack_reg (default params).
// Honours STATUS_STACK_ROTATE_EN for the pop-only expectations.
module tb_status_stack_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    status_stack_if #(.WIDTH(32), .FIELD_W(4)) bus ();

    status_stack_reg #(
        .WIDTH(32), .FIELD_W(4), .RESET_VAL(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic idle();
        bus.push = 0; bus.pop = 0; bus.new_field = '0;
        bus.wr_en = 0; bus.wr_data = '0; bus.clr_flags = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_write(input logic [31:0] d);
        bus.wr_en = 1; bus.wr_data = d; step();
    endtask

    task automatic do_push(input logic [3:0] f);
        bus.push = 1; bus.new_field = f; step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; bus.push = 1; bus.new_field = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        n_chk++; if (bus.status_q !== 32'h0) begin n_fail++; $display("FAIL rst_status got %h exp %h", bus.status_q, 32'h0); end
        n_chk++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", bus.level); end
        n_chk++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b exp 00", bus.ovf, bus.udf); end
        n_chk++; if (bus.popped_field !== 4'h0) begin n_fail++; $display("FAIL rst_popped got %h exp 0", bus.popped_field); end
        rst_n = 1; idle();
    endtask

    task automatic test_push_pop();
        do_write(32'h0000_0003);
        do_push(4'h5);
        n_chk++; if (bus.status_q !== 32'h0000_0035) begin n_fail++; $display("FAIL push_status got %h exp 00000035", bus.status_q); end
        n_chk++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL push_level got %0d exp 1", bus.level); end
        bus.pop = 1; step();
        n_chk++; if (bus.status_q !== 32'h0000_0003) begin n_fail++; $display("FAIL pop_status got %h exp 00000003", bus.status_q); end
        n_chk++; if (bus.popped_field !== 4'h5) begin n_fail++; $display("FAIL pop_popped got %h exp 5", bus.popped_field); end
        n_chk++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL pop_level got %0d exp 0", bus.level); end
        step();
        n_chk++; if (bus.status_q !== 32'h0000_0003 || bus.popped_field !== 4'h5) begin n_fail++; $display("FAIL hold got %h/%h exp 00000003/5", bus.status_q, bus.popped_field); end
    endtask

    task automatic test_overflow();
        do_write(32'h0);
        for (int i = 1; i <= 8; i++) do_push(4'(i));
        n_chk++; if (bus.status_q !== 32'h1234_5678) begin n_fail++; $display("FAIL full_status got %h exp 12345678", bus.status_q); end
        n_chk++; if (bus.level !== 4'd8 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL full_lvl_ovf got %0d/%b exp 8/0", bus.level, bus.ovf); end
        do_push(4'h9);
        n_chk++; if (bus.status_q !== 32'h2345_6789) begin n_fail++; $display("FAIL ovf_status got %h exp 23456789", bus.status_q); end
        n_chk++; if (bus.level !== 4'd8 || bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_lvl_flag got %0d/%b exp 8/1", bus.level, bus.ovf); end
        bus.clr_flags = 1; step();
        n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", bus.ovf); end
        bus.clr_flags = 1; bus.push = 1; bus.new_field = 4'hA; step();
        n_chk++; if (bus.ovf !== 1'b1 || bus.status_q !== 32'h3456_789A) begin n_fail++; $display("FAIL ovf_set_wins got %b/%h exp 1/3456789a", bus.ovf, bus.status_q); end
        bus.clr_flags = 1; step();
    endtask

    task automatic test_underflow();
        logic [31:0] exp1;
`ifdef STATUS_STACK_ROTATE_EN
        exp1 = 32'hBA00_0000;
`else
        exp1 = 32'h0A00_0000;
`endif
        do_write(32'hA000_000B);
        bus.pop = 1; step();
        n_chk++; if (bus.status_q !== exp1) begin n_fail++; $display("FAIL udf_status got %h exp %h", bus.status_q, exp1); end
        n_chk++; if (bus.popped_field !== 4'hB) begin n_fail++; $display("FAIL udf_popped got %h exp b", bus.popped_field); end
        n_chk++; if (bus.udf !== 1'b1 || bus.level !== 4'd0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL udf_flag got udf=%b lvl=%0d ovf=%b exp 1/0/0", bus.udf, bus.level, bus.ovf); end
        bus.pop = 1; bus.clr_flags = 1; step();
        n_chk++; if (bus.udf !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins got %b exp 1", bus.udf); end
        bus.clr_flags = 1; step();
        n_chk++; if (bus.udf !== 1'b0) begin n_fail++; $display("FAIL udf_clr got %b exp 0", bus.udf); end
    endtask

    task automatic test_push_and_pop();
        do_write(32'h0000_0001);
        do_push(4'h2);
        bus.push = 1; bus.pop = 1; bus.new_field = 4'h7; step();
        n_chk++; if (bus.status_q !== 32'h0000_0017) begin n_fail++; $display("FAIL pp_status got %h exp 00000017", bus.status_q); end
        n_chk++; if (bus.popped_field !== 4'h2 || bus.level !== 4'd1) begin n_fail++; $display("FAIL pp_pop_lvl got %h/%0d exp 2/1", bus.popped_field, bus.level); end
        n_chk++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin n_fail++; $display("FAIL pp_flags got %b%b exp 00", bus.ovf, bus.udf); end
    endtask

    task automatic test_back_to_back();
        do_write(32'h0);
        do_push(4'h0); do_push(4'h0); do_push(4'h0);
        n_chk++; if (bus.level !== 4'd3) begin n_fail++; $display("FAIL wr_pre_level got %0d exp 3", bus.level); end
        bus.wr_en = 1; bus.wr_data = 32'hDEAD_BEEF; bus.push = 1; bus.new_field = 4'hC; step();
        n_chk++; if (bus.status_q !== 32'hDEAD_BEEF || bus.level !== 4'd0) begin n_fail++; $display("FAIL wr_status_lvl got %h/%0d exp deadbeef/0", bus.status_q, bus.level); end
        n_chk++; if (bus.popped_field !== 4'h2) begin n_fail++; $display("FAIL wr_popped_hold got %h exp 2", bus.popped_field); end
        do_push(4'h1);
        n_chk++; if (bus.status_q !== 32'hEADB_EEF1 || bus.level !== 4'd1) begin n_fail++; $display("FAIL wr_then_push got %h/%0d exp eadbeef1/1", bus.status_q, bus.level); end
        rst_n = 0; step(); rst_n = 1;
        n_chk++; if (bus.status_q !== 32'h0 || bus.level !== 4'd0) begin n_fail++; $display("FAIL midrst got %h/%0d exp 0/0", bus.status_q, bus.level); end
    endtask

    initial begin
        idle();
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_push_and_pop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/status_stack_reg.md
Name: status_stack_reg

Overview:
- Registered successor to the fixed 4-bit status shifter: holds a WIDTH-bit status word as a stack of FIELD_W-bit fields.
- On exception entry, push shifts the word left by one field and inserts a new field at the bottom.
- On exception return, pop shifts the word right by one field.
- Sits in the CP0/exception path; the CP0 move logic can write the word directly.
- Tracks stack depth and reports overflow and underflow through sticky flags.

Parameters:
- WIDTH, 32, status word width; must be an integer multiple of FIELD_W.
- FIELD_W, 4, bits per stacked field (shift amount per push/pop).
- RESET_VAL, 32'h0000_0000, value loaded into status_q on reset (truncated to WIDTH).
- DEPTH (localparam), WIDTH/FIELD_W, number of field slots.
- LVL_W (localparam), clog2(DEPTH+1), width of level.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- push  in  1  exception entry: shift left one field, insert new_field.
- pop  in  1  exception return: shift right one field.
- new_field  in  FIELD_W  field inserted at bits [FIELD_W-1:0] on push.
- wr_en  in  1  direct write of whole word (mtc0).
- wr_data  in  WIDTH  data for direct write.
- clr_flags  in  1  clears ovf/udf sticky flags.
- status_q  out  WIDTH  current status word (registered).
- popped_field  out  FIELD_W  field discarded by the last pop (registered).
- level  out  LVL_W  number of pushed-but-not-popped fields, saturating 0..DEPTH.
- ovf  out  1  sticky: a push occurred at level==DEPTH.
- udf  out  1  sticky: a pop occurred at level==0.

Behaviour:
- All state updates on rising clk; all outputs come from registers; 1-cycle latency from command to visible result.
- Reset (rst_n=0 at edge) overrides everything: status_q=RESET_VAL, popped_field=0, level=0, ovf=0, udf=0. Reset mid-sequence discards all stack history.
- Priority per cycle: reset > wr_en > push/pop.
- wr_en=1: status_q<=wr_data; level<=0; popped_field held; push/pop ignored that cycle; flags unaffected except by clr_flags.
- push only:
  - status_q <= {status_q[WIDTH-FIELD_W-1:0], new_field}.
  - If level<DEPTH, level+1.
  - Else level stays DEPTH, ovf<=1, and the top field is lost.
- pop only:
  - status_q <= {FIELD_W'b0, status_q[WIDTH-1:FIELD_W]}; popped_field <= status_q[FIELD_W-1:0].
  - If level>0, level-1.
  - Else level stays 0, udf<=1; the shift still occurs.
- push and pop same cycle (return immediately re-excepting):
  - status_q <= {status_q[WIDTH-1:FIELD_W], new_field}, i.e. bottom field replaced.
  - popped_field <= old bottom field.
  - level unchanged; no ovf/udf.
- clr_flags=1: ovf/udf <= 0, unless the same cycle sets them; set wins over clear.
- Neither push nor pop nor wr_en: status_q, level and popped_field hold.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: STATUS_STACK_ROTATE_EN.
- Defined: pop-only rotates instead of zero-filling: status_q <= {status_q[FIELD_W-1:0], status_q[WIDTH-1:FIELD_W]}.
  - The popped field re-enters at the top, so a full push/pop cycle is lossless when level never exceeds DEPTH.
  - The push+pop case is unchanged.
- Undefined: pop-only zero-fills the top field as described above.
- level/ovf/udf behaviour is identical in both builds.

Test Plan:
1. Reset: hold rst_n=0 two cycles with push=1 -> status_q=RESET_VAL, level=0, ovf=udf=0, popped_field=0.
2. From status_q=32'h0000_0003, push new_field=4'h5 -> status_q=32'h0000_0035, level=1. Then pop -> status_q=32'h0000_0003, popped_field=4'h5, level=0.
3. Push 8 times with new_field=1..8 from 0 -> status_q=32'h1234_5678, level=8, ovf=0. A 9th push with 4'h9 -> status_q=32'h2345_6789, level=8, ovf=1. clr_flags -> ovf=0.
4. At level=0, status_q=32'hA000_000B, pop:
   - Without macro -> status_q=32'h0A00_0000, popped_field=4'hB, udf=1, level=0.
   - With STATUS_STACK_ROTATE_EN -> status_q=32'hBA00_0000.
5. push+pop together, status_q=32'h0000_0012, new_field=4'h7, level=1 -> status_q=32'h0000_0017, popped_field=4'h2, level=1, no flags.
6. wr_en=1 with wr_data=32'hDEAD_BEEF and push=1, pop=0 at level=3 -> status_q=32'hDEAD_BEEF, level=0. Push ignored. Next-cycle push with new_field=4'h1 -> status_q=32'hEADB_EEF1.
